alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//  Parametrised sequential successor to the team's combinational 8-bit ALU. Adds the following:
//  - a WIDTH parameter
//  - valid/ready handshakes on the operand and result sides
//  - registered results with Z/N/V/C flags
//  - a stored carry for multi-word add chains (ADDC)
//  - an iterative shift-add multiplier
//  Sits between an operand source (sequencer/CPU datapath) and a result consumer.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; power of 2, >= 4
//  SHW    $clog2(WIDTH)  shift-amount width; derived, not overridden
// PORTS
//  clk      in   1      clock; all logic on rising edge
//  rst      in   1      synchronous active-high reset
//  i_valid  in   1      operand bundle valid
//  o_ready  out  1      block can accept an operand bundle this cycle
//  i_a      in   WIDTH  operand A
//  i_b      in   WIDTH  operand B; shift amount = i_b[SHW-1:0]
//  i_op     in   4      opcode (see BEHAVIOUR)
//  o_valid  out  1      result valid
//  i_ready  in   1      consumer accepts result this cycle
//  o_res    out  WIDTH  result
//  o_carry  out  1      carry/borrow of this result
//  o_zero   out  1      o_res == 0
//  o_neg    out  1      o_res[WIDTH-1]
//  o_ovf    out  1      signed overflow (ADD/SUB/ADDC only, else 0)
//  o_err    out  1      illegal opcode; o_res = 0, all flags 0
// BEHAVIOUR
//  Reset: state=IDLE; o_valid, o_res, all flags, o_err, stored carry = 0; o_ready=1 the cycle after rst drops.
//  Opcodes:
//   0 ADD; 1 SUB (A-B); 2 AND; 3 OR; 4 XOR; 5 NOT A; 6 SHR (logical); 7 SHL; 8 ASR (arithmetic);
//   9 ADDC (A+B+stored carry); 10 MUL (low WIDTH bits of A*B); 11-15 illegal.
//  Carry:
//   - ADD/ADDC: carry-out.
//   - SUB: borrow (1 when A<B unsigned).
//   - All other ops: o_carry=0.
//   - Stored carry updated only on completion of ADD/SUB/ADDC.
//  Overflow:
//   - ADD/ADDC: operands have the same sign and the result sign differs.
//   - SUB: operands have different signs and the result sign differs from A.
//  Shifts: amount 0 passes A through unchanged.
//  Transfer rules:
//   - Operand accepted on an edge where i_valid & o_ready.
//   - Result consumed on an edge where o_valid & i_ready.
//  FSM states:
//   - IDLE: o_ready=1. Accept with op!=MUL -> DONE, result registered on the accept edge. Accept with MUL -> BUSY.
//   - BUSY: o_ready=0. One partial-product step per cycle over WIDTH cycles, then -> DONE.
//   - DONE: o_valid=1; outputs stable until consumed. o_ready=i_ready, so consume+accept on the same edge is allowed (back-to-back). Consume without a new accept -> IDLE.
//  Latency, from the accept edge to the first o_valid=1 cycle:
//   - Single-cycle ops: 1 cycle; full throughput of 1 op/cycle when i_ready=1.
//   - MUL: WIDTH+1 cycles; no new accept while BUSY.
//  Input sampling: i_a/i_b/i_op are sampled only on the accept edge; later changes are ignored (MUL latches its operands).
//  Reset mid-operation (BUSY or DONE): the operation is discarded, no o_valid pulse, and the stored carry is cleared.
//  o_valid never drops without an i_ready handshake, except by rst.
// TESTING (WIDTH=8 unless stated)
//  1. ADD A=0x0F B=0x01 -> o_res=0x10, C=0, Z=0, N=0, V=0, o_valid 1 cycle after accept. Then ADD 0x7F+0x01 -> 0x80, V=1, N=1.
//  2. SUB A=0x02 B=0x03 -> o_res=0xFF, C=1 (borrow), N=1. SUB 0x05-0x05 -> 0x00, Z=1, C=0.
//  3. Carry chain: ADD 0xFF+0x01 -> 0x00, C=1; then ADDC 0x00+0x00 -> 0x01, C=0.
//  4. Logic/shift sweep with A=0x0F, B=0xF0/0x02:
//     - AND=0x00, OR=0xFF, XOR=0xFF, NOT=0xF0
//     - SHR=0x03, SHL=0x3C; ASR A=0x80 B=0x02 -> 0xE0
//     - op 12 -> o_err=1, o_res=0
//  5. MUL and backpressure:
//     - MUL 0x0F*0x11 -> 0xFF with o_valid exactly 9 cycles after accept; o_ready=0 throughout BUSY.
//     - Hold i_ready=0 for 5 cycles: o_res and flags stay stable.
//     - Then i_ready=1 with i_valid=1: back-to-back accept on the same edge.
//  6. Assert rst 3 cycles into a MUL -> no o_valid pulse, outputs and stored carry 0, o_ready=1 after release. A following ADDC 1+1 -> 0x02 (carry cleared).

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with operand/result valid-ready handshakes, registered Z/N/V/C flags,
// a stored carry for ADDC chains and an iterative shift-add multiplier.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [3:0]       i_op,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_res,
    output logic             o_carry,
    output logic             o_zero,
    output logic             o_neg,
    output logic             o_ovf,
    output logic             o_err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHR  = 4'd6;
    localparam logic [3:0] OP_SHL  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_ADDC = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             cin_q, cin_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] alu_res_s;
    logic             alu_c_s;
    logic             alu_v_s;
    logic             alu_err_s;
    logic             alu_cupd_s;
    logic [WIDTH:0]   sum_s;
    logic [SHW-1:0]   sh_s;
    logic             accept_s;
    logic             ready_s;

    // Single-cycle datapath: result, carry/borrow, overflow and illegal-op detection.
    always_comb begin
        alu_res_s  = '0;
        alu_c_s    = 1'b0;
        alu_v_s    = 1'b0;
        alu_err_s  = 1'b0;
        alu_cupd_s = 1'b0;
        sum_s      = '0;
        sh_s       = i_b[SHW-1:0];
        case (i_op)
            OP_ADD, OP_ADDC: begin
                sum_s      = {1'b0, i_a} + {1'b0, i_b}
                           + {{WIDTH{1'b0}}, (i_op == OP_ADDC) ? cin_q : 1'b0};
                alu_res_s  = sum_s[WIDTH-1:0];
                alu_c_s    = sum_s[WIDTH];
                alu_v_s    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (sum_s[WIDTH-1] != i_a[WIDTH-1]);
                alu_cupd_s = 1'b1;
            end
            OP_SUB: begin
                // Top bit of the widened difference is the unsigned borrow.
                sum_s      = {1'b0, i_a} - {1'b0, i_b};
                alu_res_s  = sum_s[WIDTH-1:0];
                alu_c_s    = sum_s[WIDTH];
                alu_v_s    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (sum_s[WIDTH-1] != i_a[WIDTH-1]);
                alu_cupd_s = 1'b1;
            end
            OP_AND:  alu_res_s = i_a & i_b;
            OP_OR:   alu_res_s = i_a | i_b;
            OP_XOR:  alu_res_s = i_a ^ i_b;
            OP_NOT:  alu_res_s = ~i_a;
            OP_SHR:  alu_res_s = i_a >> sh_s;
            OP_SHL:  alu_res_s = i_a << sh_s;
            OP_ASR:  alu_res_s = WIDTH'($signed(i_a) >>> sh_s);
            OP_MUL:  alu_res_s = '0;
            default: alu_err_s = 1'b1;
        endcase
    end

    // Handshake FSM, multiplier iteration and result/flag register update.
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        cin_d    = cin_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE:  ready_s = 1'b1;
            S_DONE:  ready_s = i_ready;
            default: ready_s = 1'b0;
        endcase
        accept_s = i_valid & ready_s;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept_s) begin
                    if (i_op == OP_MUL) begin
                        state_d  = S_BUSY;
                        mcand_d  = i_a;
                        mplier_d = i_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                    end else begin
                        state_d = S_DONE;
                        res_d   = alu_res_s;
                        carry_d = alu_c_s;
                        zero_d  = (alu_res_s == '0) && !alu_err_s;
                        neg_d   = alu_res_s[WIDTH-1];
                        ovf_d   = alu_v_s;
                        err_d   = alu_err_s;
                        if (alu_cupd_s) begin
                            cin_d = alu_c_s;
                        end else begin
                            cin_d = cin_q;
                        end
                    end
                end else if ((state_q == S_DONE) && i_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            S_BUSY: begin
                // WIDTH accumulate steps, then one edge to publish the product.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    res_d   = acc_q;
                    carry_d = 1'b0;
                    zero_d  = (acc_q == '0);
                    neg_d   = acc_q[WIDTH-1];
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                end else begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : {WIDTH{1'b0}});
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cin_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            cin_q    <= cin_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_ready = ready_s;
    assign o_valid = (state_q == S_DONE);
    assign o_res   = res_q;
    assign o_carry = carry_q;
    assign o_zero  = zero_q;
    assign o_neg   = neg_q;
    assign o_ovf   = ovf_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops run back-to-back,
// plus hand-written MUL latency/backpressure and mid-operation reset sequences.
module tb_alu_seq;

    logic       clk;
    logic       rst;
    logic       i_valid;
    logic       o_ready;
    logic [7:0] i_a;
    logic [7:0] i_b;
    logic [3:0] i_op;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_res;
    logic       o_carry;
    logic       o_zero;
    logic       o_neg;
    logic       o_ovf;
    logic       o_err;

    int checks   = 0;
    int failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_op    (i_op),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_carry (o_carry),
        .o_zero  (o_zero),
        .o_neg   (o_neg),
        .o_ovf   (o_ovf),
        .o_err   (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       e;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] res, input logic c,
                             input logic z, input logic n, input logic v, input logic e);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_res"},   32'(o_res),   32'(res));
        check({tag, "_flags"}, {27'd0, o_carry, o_zero, o_neg, o_ovf, o_err},
                               {27'd0, c, z, n, v, e});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        //            op     a      b      res    c     z     n     v     e
        vecs[0]  = '{4'd0,  8'h0F, 8'h01, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{4'd1,  8'h02, 8'h03, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'd1,  8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd9,  8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd2,  8'h0F, 8'hF0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{4'd3,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'd4,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'd5,  8'h0F, 8'hF0, 8'hF0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{4'd6,  8'h0F, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd7,  8'h0F, 8'h02, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{4'd8,  8'h80, 8'h02, 8'hE0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{4'd6,  8'h0F, 8'hF0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{4'd12, 8'h0F, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{4'd1,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{4'd0,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0;
        i_a = 8'h00; i_b = 8'h00; i_op = 4'd0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_res",   32'(o_res),   32'd0);
        check("rst_flags", {27'd0, o_carry, o_zero, o_neg, o_ovf, o_err}, 32'd0);

        // Back-to-back table run: i_valid and i_ready held high throughout.
        i_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            i_valid = 1'b1; i_op = vecs[i].op; i_a = vecs[i].a; i_b = vecs[i].b;
            tick();
            check_out($sformatf("v%0d", i), vecs[i].res, vecs[i].c, vecs[i].z,
                      vecs[i].n, vecs[i].v, vecs[i].e);
        end
        i_valid = 1'b0;
        tick();
        check("drain_valid", 32'(o_valid), 32'd0);

        // MUL: exactly 9 cycles to o_valid, o_ready low while busy, operands latched.
        i_ready = 1'b0; i_valid = 1'b1; i_op = 4'd10; i_a = 8'h0F; i_b = 8'h11;
        tick();
        i_valid = 1'b0; i_a = 8'hAA; i_b = 8'h55; i_op = 4'd0;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("mul_busy_valid%0d", k), 32'(o_valid), 32'd0);
            check($sformatf("mul_busy_ready%0d", k), 32'(o_ready), 32'd0);
            tick();
        end
        check_out("mul", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_out($sformatf("hold%0d", k), 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            check($sformatf("hold_ready%0d", k), 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1; i_valid = 1'b1; i_op = 4'd0; i_a = 8'h01; i_b = 8'h01;
        #1;
        check("b2b_ready", 32'(o_ready), 32'd1);
        tick();
        check_out("b2b", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        tick();
        check("b2b_drain", 32'(o_valid), 32'd0);

        // Set stored carry, start a MUL, reset 3 cycles in.
        i_valid = 1'b1; i_op = 4'd0; i_a = 8'hFF; i_b = 8'h01;
        tick();
        check_out("pre_c", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        i_op = 4'd10; i_a = 8'h0F; i_b = 8'h11;
        tick();
        i_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        check("rstm_valid", 32'(o_valid), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("rstm_res",   32'(o_res), 32'd0);
        check("rstm_flags", {27'd0, o_carry, o_zero, o_neg, o_ovf, o_err}, 32'd0);
        check("rstm_ready", 32'(o_ready), 32'd1);
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("rstm_nopulse%0d", k), 32'(o_valid), 32'd0);
        end
        i_valid = 1'b1; i_op = 4'd9; i_a = 8'h01; i_b = 8'h01;
        tick();
        check_out("addc_after_rst", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
